next_pc_sequencer: RTL
======================

// Module: next_pc_sequencer
// PURPOSE
//  Owns the program counter and sequences next-PC selection for the pipelined MIPS core.
//  Arbitrates fetch redirects from three sources: taken branch from EX, JR from ID and
//  J/JAL from ID (target built by the jump-address unit). Drives the IF/ID flush.
//  Holds the PC on a hazard stall and buffers a redirect that arrives during the stall.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  PC_INC        4              sequential increment, in bytes
// PORTS
//  Clk            in   1   core clock, all state updates on rising edge
//  Rst_n          in   1   asynchronous, active-low reset
//  Stall          in   1   hazard unit: hold PC, no new fetch
//  Halt           in   1   ID decoded halt/break; freeze the core
//  BranchTaken    in   1   EX: branch resolved taken
//  BranchTarget   in   32  EX: branch target address
//  JumpReg        in   1   ID: JR/JALR
//  JumpRegTarget  in   32  ID: rs value
//  Jump           in   1   ID: J/JAL
//  JumpTarget     in   32  ID: {PCPlus4[31:28], imm26, 2'b00}
//  PC             out  32  current fetch address (registered)
//  PCPlus4        out  32  PC + PC_INC, combinational, 32-bit wrap
//  FetchValid     out  1   PC is a valid fetch this cycle
//  FlushIFID      out  1   squash the instruction in IF/ID (combinational)
//  AlignErr       out  1   sticky: a redirect target had bits [1:0] != 0
//  Halted         out  1   core is in HALT
// BEHAVIOUR
//  Reset (Rst_n=0, asynchronous): PC=RESET_VECTOR, state=BOOT, pending cleared,
//   FetchValid=0, FlushIFID=0, AlignErr=0, Halted=0.
//  States: BOOT, RUN, STALL, HALT.
//   BOOT: one cycle, PC held, FetchValid=0, then RUN unconditionally (inputs ignored).
//   RUN: FetchValid=1. Redirect priority: BranchTaken > JumpReg > Jump.
//    Redirect and !Stall: PC<=target, FlushIFID=1 in the same cycle. Else PC<=PCPlus4.
//    Stall=1: PC held, go to STALL. A redirect asserted this cycle goes to pending.
//    Halt=1 and !BranchTaken: go to HALT, PC held, pending discarded.
//    Halt=1 with BranchTaken: halt ignored (it is younger); branch is taken.
//   STALL: PC held, FetchValid=0, FlushIFID=0.
//    New redirect: a higher-or-equal-priority source overwrites pending; lower is dropped.
//    Stall=0: if pending, PC<=pending target, FlushIFID=1, clear pending. Else PC<=PCPlus4.
//     A redirect present in the release cycle is arbitrated against pending first.
//     Next state is RUN.
//  HALT: PC frozen, FetchValid=0, Halted=1. All inputs ignored. Exit only through reset.
//  Targets: bits [1:0] forced to 2'b00 before loading. AlignErr set, sticky until reset.
//  Wrap: PC=32'hFFFF_FFFC -> PCPlus4=32'h0000_0000, with no flag.
//  Latency: redirect to new PC is 1 cycle. A stalled redirect applies on the release edge.
//  Reset asserted mid-stall or mid-halt returns to BOOT at once. Pending is lost.
// STRUCTURE
//  mips_pkg: pc_state_t enum {BOOT,RUN,STALL,HALT}, redir_src_t enum {NONE,JMP,JR,BR}
//   (ordered by priority), RESET_VECTOR_DEFAULT.
//  Sub-module redirect_arbiter (combinational): takes the 3 requests and the pending entry.
//   Returns the winning redir_src_t and its target. This block adds the PC register, FSM,
//   pending register (src+target) and AlignErr flag.
// TESTING
//  Reset release, no redirects -> BOOT 1 cycle with PC=0, then PC=0,4,8 with FetchValid=1.
//  PC=0x40: BranchTaken(0x100) + Jump(0x200) same cycle -> PC=0x100 next, FlushIFID=1 once.
//  Stall high 3 cycles at PC=0x20 with Jump(0x80) in cycle 1 and BranchTaken(0x90) in
//   cycle 2 -> PC held at 0x20, then PC=0x90 with FlushIFID=1 on release.
//  Stall with pending BR(0x90) and Jump(0x80) in cycle 3 -> on release PC=0x90.
//  Halt at PC=0x10 -> Halted=1, FetchValid=0, PC=0x10 stays put. Halt+BranchTaken(0x50)
//   -> PC=0x50, stays in RUN.
//  JumpReg target 0x103 -> PC=0x100, AlignErr=1. PC=0xFFFFFFFC -> 0x0.
//  Rst_n low mid-stall with pending -> async PC=0. After release no pending redirect applies.

Source files
------------

// File: rtl/next_pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_sequencer_pkg
// Purpose  : Shared types for the next-PC sequencer (FSM states, redirect
//            sources ordered by priority) and target alignment helper.
// Revision : 1.0
// ============================================================================
package next_pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } pc_state_t;

  // Numeric order is the arbitration priority: a larger value wins.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    JMP  = 2'd1,
    JR   = 2'd2,
    BR   = 2'd3
  } redir_src_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_target(input logic [31:0] t);
    return t & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_sequencer_redirect_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_sequencer_redirect_arbiter
// Purpose  : Picks the winning fetch redirect among branch, JR, jump and the
//            buffered pending entry; returns source, aligned target, misalign.
// Revision : 1.0
// ============================================================================
module next_pc_sequencer_redirect_arbiter
  import next_pc_sequencer_pkg::*;
(
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  redir_src_t  pend_src,
  input  logic [31:0] pend_target,
  output redir_src_t  win_src,
  output logic [31:0] win_target,
  output logic        win_misaligned
);

  redir_src_t  w_req_src;
  logic [31:0] w_req_raw;
  logic        w_req_wins;

  always_comb begin
    w_req_src = NONE;
    w_req_raw = 32'h0000_0000;
    if (branch_taken) begin
      w_req_src = BR;
      w_req_raw = branch_target;
    end else if (jump_reg) begin
      w_req_src = JR;
      w_req_raw = jump_reg_target;
    end else if (jump) begin
      w_req_src = JMP;
      w_req_raw = jump_target;
    end
  end

  // Equal priority replaces the pending entry: the newer request is the live one.
  assign w_req_wins     = (w_req_src != NONE) && (w_req_src >= pend_src);
  assign win_src        = w_req_wins ? w_req_src : pend_src;
  assign win_target     = w_req_wins ? align_target(w_req_raw) : pend_target;
  assign win_misaligned = w_req_wins && (w_req_raw[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/next_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_sequencer
// Purpose  : Program counter, next-PC FSM, stall-time redirect buffer and
//            IF/ID flush generation for the pipelined MIPS core.
// Revision : 1.0
// ============================================================================
module next_pc_sequencer
  import next_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          PC_INC       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush_ifid,
  output logic        align_err,
  output logic        halted
);

  localparam logic [31:0] c_pc_inc = 32'(PC_INC);

  pc_state_t   r_state;
  pc_state_t   w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  redir_src_t  r_pend_src;
  redir_src_t  w_pend_src_nxt;
  logic [31:0] r_pend_tgt;
  logic [31:0] w_pend_tgt_nxt;
  logic        r_align_err;
  logic        w_align_set;
  logic        w_fetch_valid;
  logic        w_flush;

  redir_src_t  w_win_src;
  logic [31:0] w_win_tgt;
  logic        w_win_mis;

  next_pc_sequencer_redirect_arbiter u_arb (
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump_reg        (jump_reg),
    .jump_reg_target (jump_reg_target),
    .jump            (jump),
    .jump_target     (jump_target),
    .pend_src        (r_pend_src),
    .pend_target     (r_pend_tgt),
    .win_src         (w_win_src),
    .win_target      (w_win_tgt),
    .win_misaligned  (w_win_mis)
  );

  assign pc_plus4 = r_pc + c_pc_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= BOOT;
      r_pc        <= RESET_VECTOR;
      r_pend_src  <= NONE;
      r_pend_tgt  <= 32'h0000_0000;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_pend_src  <= w_pend_src_nxt;
      r_pend_tgt  <= w_pend_tgt_nxt;
      r_align_err <= r_align_err | w_align_set;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_src_nxt = r_pend_src;
    w_pend_tgt_nxt = r_pend_tgt;
    w_fetch_valid  = 1'b0;
    w_flush        = 1'b0;
    w_align_set    = 1'b0;

    unique case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end

      RUN: begin
        w_fetch_valid = 1'b1;
        // A taken branch is older than the halting instruction, so it overrides halt.
        if (halt && !branch_taken) begin
          w_state_nxt    = HALT;
          w_pend_src_nxt = NONE;
        end else if (stall) begin
          w_state_nxt    = STALL;
          w_pend_src_nxt = w_win_src;
          w_pend_tgt_nxt = w_win_tgt;
          w_align_set    = w_win_mis;
        end else if (w_win_src != NONE) begin
          w_pc_nxt       = w_win_tgt;
          w_flush        = 1'b1;
          w_align_set    = w_win_mis;
          w_pend_src_nxt = NONE;
        end else begin
          w_pc_nxt = pc_plus4;
        end
      end

      STALL: begin
        if (stall) begin
          w_pend_src_nxt = w_win_src;
          w_pend_tgt_nxt = w_win_tgt;
          w_align_set    = w_win_mis;
        end else begin
          w_state_nxt    = RUN;
          w_pend_src_nxt = NONE;
          if (w_win_src != NONE) begin
            w_pc_nxt    = w_win_tgt;
            w_flush     = 1'b1;
            w_align_set = w_win_mis;
          end else begin
            w_pc_nxt = pc_plus4;
          end
        end
      end

      HALT: begin
        w_state_nxt = HALT;
      end

      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  assign pc          = r_pc;
  assign fetch_valid = w_fetch_valid;
  assign flush_ifid  = w_flush;
  assign align_err   = r_align_err;
  assign halted      = (r_state == HALT);

endmodule
`default_nettype wire
